// File: rtl/div32_seq.sv
// div32_seq: restoring shift-subtract integer divider for DIV/DIVU.
// Quotient drives LO and Remainder drives HI, with a fixed 34-cycle latency.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  // RESULT is the cycle between the sign fix and the output write; Busy is already low there.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    FIX    = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } divState_t;

  divState_t        state;
  divState_t        stateNext;

  logic             signedR;
  logic             s1R;
  logic             s2R;
  logic [WIDTH-1:0] rawDividendR;
  logic [WIDTH-1:0] dvdR;
  logic [WIDTH-1:0] dvsR;
  logic [WIDTH-1:0] remR;
  logic [CW-1:0]    cntR;
  logic [WIDTH-1:0] fixQuotR;
  logic [WIDTH-1:0] fixRemR;
  logic             fixZeroR;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic             trialNeg;
  logic             lastIter;
  logic [WIDTH-1:0] fixQuot;
  logic [WIDTH-1:0] fixRem;
  logic             fixZero;

  function automatic logic [WIDTH-1:0] negIf(input logic neg, input logic [WIDTH-1:0] v);
    if (neg) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // WIDTH+1 bits is enough: a set top bit of remShift always means the trial succeeds.
  assign remShift = {remR, dvdR[WIDTH-1]};
  assign trial    = remShift - {1'b0, dvsR};
  assign trialNeg = trial[WIDTH];
  assign lastIter = (cntR == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Start) begin
          stateNext = CALC;
        end else begin
          stateNext = IDLE;
        end
      end
      CALC: begin
        if (lastIter) begin
          stateNext = FIX;
        end else begin
          stateNext = CALC;
        end
      end
      FIX:    stateNext = RESULT;
      RESULT: stateNext = DONE;
      DONE: begin
        if (Start) begin
          stateNext = CALC;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Sign and zero-divisor correction of the magnitude results.
  always_comb begin
    fixQuot = dvdR;
    fixRem  = remR;
    fixZero = 1'b0;
    if (dvsR == {WIDTH{1'b0}}) begin
      fixQuot = {WIDTH{1'b1}};
      fixRem  = rawDividendR;
      fixZero = 1'b1;
    end else if (signedR) begin
      fixQuot = negIf(s1R ^ s2R, dvdR);
      fixRem  = negIf(s1R, remR);
    end else begin
      fixQuot = dvdR;
      fixRem  = remR;
    end
  end

  // Operand capture, shift-subtract iterations and corrected-result staging.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      signedR      <= 1'b0;
      s1R          <= 1'b0;
      s2R          <= 1'b0;
      rawDividendR <= {WIDTH{1'b0}};
      dvdR         <= {WIDTH{1'b0}};
      dvsR         <= {WIDTH{1'b0}};
      remR         <= {WIDTH{1'b0}};
      cntR         <= {CW{1'b0}};
      fixQuotR     <= {WIDTH{1'b0}};
      fixRemR      <= {WIDTH{1'b0}};
      fixZeroR     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            signedR      <= Signed;
            s1R          <= DataIn1[WIDTH-1];
            s2R          <= DataIn2[WIDTH-1];
            rawDividendR <= DataIn1;
            dvdR         <= negIf(Signed & DataIn1[WIDTH-1], DataIn1);
            dvsR         <= negIf(Signed & DataIn2[WIDTH-1], DataIn2);
            remR         <= {WIDTH{1'b0}};
            cntR         <= {CW{1'b0}};
          end
        end
        CALC: begin
          if (trialNeg) begin
            remR <= remShift[WIDTH-1:0];
          end else begin
            remR <= trial[WIDTH-1:0];
          end
          dvdR <= {dvdR[WIDTH-2:0], ~trialNeg};
          cntR <= cntR + CW'(1);
        end
        FIX: begin
          fixQuotR <= fixQuot;
          fixRemR  <= fixRem;
          fixZeroR <= fixZero;
        end
        default: begin
          cntR <= cntR;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; results hold until the next operation completes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= {WIDTH{1'b0}};
      Remainder <= {WIDTH{1'b0}};
      DivByZero <= 1'b0;
    end else begin
      Busy <= (stateNext == CALC) || (stateNext == FIX);
      Done <= (stateNext == DONE);
      if (state == RESULT) begin
        Quotient  <= fixQuotR;
        Remainder <= fixRemR;
        DivByZero <= fixZeroR;
      end
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed DIV/DIVU cases, back-to-back issue,
// ignored Start while busy, and asynchronous reset in mid-calculation.
module tb_div32_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        Signed;
  logic [31:0] DataIn1;
  logic [31:0] DataIn2;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  int   nAssert = 0;
  int   nFail   = 0;
  exp_t sb[$];

  div32_seq #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Signed    (Signed),
    .DataIn1   (DataIn1),
    .DataIn2   (DataIn2),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else if (sg) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      e.q = 32'(sa / sbv);
      e.r = 32'(sa % sbv);
      e.z = 1'b0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called #1 after a rising edge; Start is seen at the next edge (E0).
  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b, input logic push);
    Start   = 1'b1;
    Signed  = sg;
    DataIn1 = a;
    DataIn2 = b;
    if (push) sb.push_back(model(sg, a, b));
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Called #1 after E0; returns #1 after the edge that raises Done.
  task automatic waitDone(input string tag, input int injectAt);
    int   cycles     = 0;
    int   busyCycles = 0;
    exp_t e;
    while (Done !== 1'b1 && cycles < 100) begin
      if (Busy === 1'b1) busyCycles++;
      if (cycles == injectAt) begin
        Start   = 1'b1;
        Signed  = 1'b1;
        DataIn1 = 32'hDEAD_BEEF;
        DataIn2 = 32'h0000_0003;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk);
      #1;
      cycles++;
    end
    Start = 1'b0;
    check({tag, ".latency"}, 64'(cycles), 64'd34);
    check({tag, ".busyCycles"}, 64'(busyCycles), 64'd33);
    check({tag, ".busyAtDone"}, 64'(Busy), 64'd0);
    nAssert++;
    assert (sb.size() > 0) else begin
      nFail++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".quotient"}, 64'(Quotient), 64'(e.q));
      check({tag, ".remainder"}, 64'(Remainder), 64'(e.r));
      check({tag, ".divByZero"}, 64'(DivByZero), 64'(e.z));
    end
  endtask

  initial begin
    int          seen;
    logic [31:0] a;
    logic [31:0] b;

    Rst_n   = 1'b0;
    Start   = 1'b0;
    Signed  = 1'b0;
    DataIn1 = 32'd0;
    DataIn2 = 32'd0;
    idle(2);
    check("reset.busy", 64'(Busy), 64'd0);
    check("reset.done", 64'(Done), 64'd0);
    check("reset.quotient", 64'(Quotient), 64'd0);
    check("reset.remainder", 64'(Remainder), 64'd0);
    check("reset.divByZero", 64'(DivByZero), 64'd0);
    Rst_n = 1'b1;
    idle(2);

    // Unsigned 100 / 7, then check Done is a single pulse and results hold.
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    waitDone("u100div7", -1);
    idle(1);
    check("pulse.doneLow", 64'(Done), 64'd0);
    check("pulse.busyLow", 64'(Busy), 64'd0);
    check("hold.quotient", 64'(Quotient), 64'h0000_000E);
    idle(2);

    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    waitDone("sNeg7div2", -1);

    // Back-to-back chain issued in each Done cycle.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone("sOverflow", -1);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone("uOverflowOps", -1);
    issue(1'b0, 32'd5, 32'd0, 1'b1);
    waitDone("uDivZero", -1);
    issue(1'b1, 32'd5, 32'd0, 1'b1);
    waitDone("sDivZero", -1);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1);
    waitDone("sNegDivZero", -1);

    // Start with other operands at cycle 10 of a busy division is ignored.
    idle(3);
    issue(1'b0, 32'd1000, 32'd33, 1'b1);
    waitDone("ignoreStart", 10);
    issue(1'b1, 32'd12345, 32'hFFFF_FFEF, 1'b1);
    waitDone("backToBack", -1);

    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      b = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom();
      issue(i[0], a, b, 1'b1);
      waitDone($sformatf("rand%0d", i), -1);
    end

    // Reset in CALC cycle 15: immediate IDLE, outputs cleared, no Done afterwards.
    idle(2);
    issue(1'b0, 32'h0000_FFFF, 32'h0000_0011, 1'b0);
    repeat (15) @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check("midReset.busy", 64'(Busy), 64'd0);
    check("midReset.done", 64'(Done), 64'd0);
    check("midReset.quotient", 64'(Quotient), 64'd0);
    check("midReset.remainder", 64'(Remainder), 64'd0);
    check("midReset.divByZero", 64'(DivByZero), 64'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1 || Busy === 1'b1) seen++;
    end
    check("afterReset.noActivity", 64'(seen), 64'd0);
    issue(1'b0, 32'd9, 32'd3, 1'b1);
    waitDone("u9div3", -1);

    check("scoreboard.drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
